// File: rtl/discharge_param_scheduler_if.sv
// Command/parameter bus between the SPI/key sources, the scheduler and the MOSFET controller.
// The slave modport is the scheduler's view; master is the driving side.
interface discharge_param_scheduler_if;
  logic        machine_start_ack_spi;
  logic        machine_stop_ack_spi;
  logic        machine_start_ack_key;
  logic        machine_stop_ack_key;
  logic        change_Ton_ack;
  logic        change_Toff_ack;
  logic        change_Ip_ack;
  logic        change_waveform_ack;
  logic [15:0] Ton_data_in;
  logic [15:0] Toff_data_in;
  logic [15:0] Ip_data_in;
  logic [15:0] waveform_data_in;
  logic        cycle_boundary;
  logic        is_operation;
  logic [15:0] Ton_data;
  logic [15:0] Toff_data;
  logic [15:0] Ip_data;
  logic [15:0] waveform_data;
  logic        is_machine;
  logic        commit_pulse;
  logic [3:0]  pending;
  logic        reject_pulse;
  logic        drain_fault;

  modport slave (
    input  machine_start_ack_spi, machine_stop_ack_spi,
    input  machine_start_ack_key, machine_stop_ack_key,
    input  change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack,
    input  Ton_data_in, Toff_data_in, Ip_data_in, waveform_data_in,
    input  cycle_boundary, is_operation,
    output Ton_data, Toff_data, Ip_data, waveform_data,
    output is_machine, commit_pulse, pending, reject_pulse, drain_fault
  );

  modport master (
    output machine_start_ack_spi, machine_stop_ack_spi,
    output machine_start_ack_key, machine_stop_ack_key,
    output change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack,
    output Ton_data_in, Toff_data_in, Ip_data_in, waveform_data_in,
    output cycle_boundary, is_operation,
    input  Ton_data, Toff_data, Ip_data, waveform_data,
    input  is_machine, commit_pulse, pending, reject_pulse, drain_fault
  );
endinterface

// File: rtl/discharge_param_scheduler.sv
// Validates and stages discharge parameter changes, commits them atomically at cycle
// boundaries, and drains the power stage before any waveform change takes effect.
module discharge_param_scheduler #(
  parameter logic [15:0] TON_DEFAULT      = 16'd10,
  parameter logic [15:0] TOFF_DEFAULT     = 16'd50,
  parameter logic [15:0] IP_DEFAULT       = 16'd20,
  parameter logic [15:0] WAVEFORM_DEFAULT = 16'h0001,
  parameter logic [15:0] TOFF_MIN         = 16'd5,
  parameter logic [15:0] IP_MAX           = 16'd78,
  parameter logic [15:0] DRAIN_TIMEOUT    = 16'd20000
) (
  input logic                           clk,
  input logic                           rst,
  discharge_param_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  state_t      state_r;
  logic [15:0] ton_r, toff_r, ip_r, wave_r;
  logic [15:0] ton_stg_r, toff_stg_r, ip_stg_r, wave_stg_r;
  logic [3:0]  pending_r;
  logic        spi_run_r, key_run_r;
  logic        is_machine_r, commit_r, reject_r, drain_fault_r;
  logic [15:0] drain_cnt_r;

  logic [3:0]  acc_s, rej_s, pending_s, commit_mask_s;
  logic [15:0] ton_stg_s, toff_stg_s, ip_stg_s, wave_stg_s;
  logic        run_req_s, timeout_s, drain_done_s;

  function automatic logic ton_ok(input logic [15:0] v);
    return v != 16'd0;
  endfunction

  function automatic logic toff_ok(input logic [15:0] v);
    return v >= TOFF_MIN;
  endfunction

  function automatic logic ip_ok(input logic [15:0] v);
    return (v != 16'd0) && (v <= IP_MAX);
  endfunction

  function automatic logic wave_ok(input logic [15:0] v);
    return (v == 16'h8000) || (v == 16'h0001) || (v == 16'h0002);
  endfunction

  assign run_req_s = spi_run_r & key_run_r;

  // Request validation and next staging contents (last accepted request wins)
  always_comb begin
    acc_s[0] = bus.change_Ton_ack      &  ton_ok(bus.Ton_data_in);
    acc_s[1] = bus.change_Toff_ack     &  toff_ok(bus.Toff_data_in);
    acc_s[2] = bus.change_Ip_ack       &  ip_ok(bus.Ip_data_in);
    acc_s[3] = bus.change_waveform_ack &  wave_ok(bus.waveform_data_in);
    rej_s[0] = bus.change_Ton_ack      & ~ton_ok(bus.Ton_data_in);
    rej_s[1] = bus.change_Toff_ack     & ~toff_ok(bus.Toff_data_in);
    rej_s[2] = bus.change_Ip_ack       & ~ip_ok(bus.Ip_data_in);
    rej_s[3] = bus.change_waveform_ack & ~wave_ok(bus.waveform_data_in);
    if (acc_s[0]) ton_stg_s  = bus.Ton_data_in;      else ton_stg_s  = ton_stg_r;
    if (acc_s[1]) toff_stg_s = bus.Toff_data_in;     else toff_stg_s = toff_stg_r;
    if (acc_s[2]) ip_stg_s   = bus.Ip_data_in;       else ip_stg_s   = ip_stg_r;
    if (acc_s[3]) wave_stg_s = bus.waveform_data_in; else wave_stg_s = wave_stg_r;
    pending_s = pending_r | acc_s;
  end

  // Which staged fields are committed at this edge; a same-cycle request is included
  always_comb begin
    commit_mask_s = 4'b0000;
    timeout_s     = bus.is_operation && (drain_cnt_r == (DRAIN_TIMEOUT - 16'd1));
    drain_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        commit_mask_s = pending_s;
      end
      ST_RUN: begin
        // Waveform changes never commit at a boundary; they go through DRAIN instead
        if (run_req_s && bus.cycle_boundary && !pending_s[3]) begin
          commit_mask_s = {1'b0, pending_s[2:0]};
        end else begin
          commit_mask_s = 4'b0000;
        end
      end
      ST_DRAIN: begin
        drain_done_s = !bus.is_operation || timeout_s;
        if (drain_done_s) begin
          commit_mask_s = pending_s;
        end else begin
          commit_mask_s = 4'b0000;
        end
      end
      ST_RESUME: begin
        commit_mask_s = 4'b0000;
      end
      default: begin
        commit_mask_s = 4'b0000;
      end
    endcase
  end

  // Scheduler FSM, run sources, staging and committed parameter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ton_r         <= TON_DEFAULT;
      toff_r        <= TOFF_DEFAULT;
      ip_r          <= IP_DEFAULT;
      wave_r        <= WAVEFORM_DEFAULT;
      ton_stg_r     <= TON_DEFAULT;
      toff_stg_r    <= TOFF_DEFAULT;
      ip_stg_r      <= IP_DEFAULT;
      wave_stg_r    <= WAVEFORM_DEFAULT;
      pending_r     <= 4'b0000;
      spi_run_r     <= 1'b0;
      key_run_r     <= 1'b1;
      is_machine_r  <= 1'b0;
      commit_r      <= 1'b0;
      reject_r      <= 1'b0;
      drain_fault_r <= 1'b0;
      drain_cnt_r   <= 16'd0;
    end else begin
      if (bus.machine_stop_ack_spi)       spi_run_r <= 1'b0;
      else if (bus.machine_start_ack_spi) spi_run_r <= 1'b1;
      if (bus.machine_stop_ack_key)       key_run_r <= 1'b0;
      else if (bus.machine_start_ack_key) key_run_r <= 1'b1;

      reject_r   <= |rej_s;
      ton_stg_r  <= ton_stg_s;
      toff_stg_r <= toff_stg_s;
      ip_stg_r   <= ip_stg_s;
      wave_stg_r <= wave_stg_s;
      pending_r  <= pending_s & ~commit_mask_s;
      commit_r   <= |commit_mask_s;
      if (commit_mask_s[0]) ton_r  <= ton_stg_s;
      if (commit_mask_s[1]) toff_r <= toff_stg_s;
      if (commit_mask_s[2]) ip_r   <= ip_stg_s;
      if (commit_mask_s[3]) wave_r <= wave_stg_s;

      case (state_r)
        ST_IDLE: begin
          if (run_req_s) begin
            state_r      <= ST_RUN;
            is_machine_r <= 1'b1;
          end else begin
            is_machine_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!run_req_s) begin
            state_r      <= ST_IDLE;
            is_machine_r <= 1'b0;
          end else if (pending_s[3]) begin
            state_r      <= ST_DRAIN;
            is_machine_r <= 1'b0;
            drain_cnt_r  <= 16'd0;
          end else begin
            is_machine_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          is_machine_r <= 1'b0;
          if (drain_done_s) begin
            if (timeout_s) drain_fault_r <= 1'b1;
            state_r <= run_req_s ? ST_RESUME : ST_IDLE;
          end else begin
            drain_cnt_r <= drain_cnt_r + 16'd1;
          end
        end
        ST_RESUME: begin
          if (run_req_s) begin
            state_r      <= ST_RUN;
            is_machine_r <= 1'b1;
          end else begin
            state_r      <= ST_IDLE;
            is_machine_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          is_machine_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ton_data      = ton_r;
  assign bus.Toff_data     = toff_r;
  assign bus.Ip_data       = ip_r;
  assign bus.waveform_data = wave_r;
  assign bus.is_machine    = is_machine_r;
  assign bus.commit_pulse  = commit_r;
  assign bus.pending       = pending_r;
  assign bus.reject_pulse  = reject_r;
  assign bus.drain_fault   = drain_fault_r;

endmodule

// File: tb/tb_discharge_param_scheduler.sv
// Self-checking bench: committed parameter sets are queued when a commit is provoked and
// compared whenever the scheduler raises commit_pulse.
module tb_discharge_param_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;
  logic [63:0] sb_q[$];

  discharge_param_scheduler_if bus();

  discharge_param_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] params();
    return {bus.Ton_data, bus.Toff_data, bus.Ip_data, bus.waveform_data};
  endfunction

  function automatic logic [63:0] pset(input logic [15:0] t, input logic [15:0] f,
                                       input logic [15:0] i, input logic [15:0] w);
    return {t, f, i, w};
  endfunction

  // Scoreboard: every commit must match the oldest expected parameter set
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.commit_pulse === 1'b1) begin
      check_eq("commit_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) check_eq("commit_params", params(), sb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] ack, input logic [15:0] ton, input logic [15:0] toff,
                     input logic [15:0] ip, input logic [15:0] wave, input logic cb);
    bus.Ton_data_in         = ton;
    bus.Toff_data_in        = toff;
    bus.Ip_data_in          = ip;
    bus.waveform_data_in    = wave;
    bus.change_Ton_ack      = ack[0];
    bus.change_Toff_ack     = ack[1];
    bus.change_Ip_ack       = ack[2];
    bus.change_waveform_ack = ack[3];
    bus.cycle_boundary      = cb;
    tick();
    bus.change_Ton_ack      = 1'b0;
    bus.change_Toff_ack     = 1'b0;
    bus.change_Ip_ack       = 1'b0;
    bus.change_waveform_ack = 1'b0;
    bus.cycle_boundary      = 1'b0;
  endtask

  task automatic runctl(input logic sa, input logic so, input logic ka, input logic ko);
    bus.machine_start_ack_spi = sa;
    bus.machine_stop_ack_spi  = so;
    bus.machine_start_ack_key = ka;
    bus.machine_stop_ack_key  = ko;
    tick();
    bus.machine_start_ack_spi = 1'b0;
    bus.machine_stop_ack_spi  = 1'b0;
    bus.machine_start_ack_key = 1'b0;
    bus.machine_stop_ack_key  = 1'b0;
  endtask

  task automatic check_defaults(input string tag);
    check_eq({tag, "_params"},  params(), pset(16'd10, 16'd50, 16'd20, 16'h0001));
    check_eq({tag, "_machine"}, 64'(bus.is_machine), 64'd0);
    check_eq({tag, "_pending"}, 64'(bus.pending), 64'd0);
    check_eq({tag, "_commit"},  64'(bus.commit_pulse), 64'd0);
    check_eq({tag, "_reject"},  64'(bus.reject_pulse), 64'd0);
    check_eq({tag, "_fault"},   64'(bus.drain_fault), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.machine_start_ack_spi = 1'b0;
    bus.machine_stop_ack_spi  = 1'b0;
    bus.machine_start_ack_key = 1'b0;
    bus.machine_stop_ack_key  = 1'b0;
    bus.change_Ton_ack = 1'b0;  bus.change_Toff_ack = 1'b0;
    bus.change_Ip_ack  = 1'b0;  bus.change_waveform_ack = 1'b0;
    bus.Ton_data_in = 16'd0;    bus.Toff_data_in = 16'd0;
    bus.Ip_data_in  = 16'd0;    bus.waveform_data_in = 16'd0;
    bus.cycle_boundary = 1'b0;
    bus.is_operation   = 1'b0;
    tick();
    tick();
    check_defaults("reset");
    rst = 1'b0;
    repeat (4) tick();

    // IDLE: commit lands the cycle after the request
    sb_q.push_back(pset(16'd30, 16'd50, 16'd20, 16'h0001));
    req(4'b0001, 16'd30, 16'd0, 16'd0, 16'd0, 1'b0);
    check_eq("idle_ton", 64'(bus.Ton_data), 64'd30);
    check_eq("idle_commit", 64'(bus.commit_pulse), 64'd1);
    check_eq("idle_pending", 64'(bus.pending), 64'd0);
    tick();
    check_eq("idle_commit_drop", 64'(bus.commit_pulse), 64'd0);

    // Start via SPI, Toff held pending until the boundary
    runctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("run_machine", 64'(bus.is_machine), 64'd1);
    req(4'b0010, 16'd0, 16'd80, 16'd0, 16'd0, 1'b0);
    check_eq("run_pending_toff", 64'(bus.pending), 64'd2);
    repeat (3) tick();
    check_eq("run_toff_held", 64'(bus.Toff_data), 64'd50);
    sb_q.push_back(pset(16'd30, 16'd80, 16'd20, 16'h0001));
    req(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    check_eq("boundary_toff", 64'(bus.Toff_data), 64'd80);
    check_eq("boundary_pending", 64'(bus.pending), 64'd0);

    // Validation: out-of-range requests rejected, pending untouched
    req(4'b0110, 16'd0, 16'd2, 16'd90, 16'd0, 1'b0);
    check_eq("reject_pulse", 64'(bus.reject_pulse), 64'd1);
    check_eq("reject_pending", 64'(bus.pending), 64'd0);
    check_eq("reject_params", params(), pset(16'd30, 16'd80, 16'd20, 16'h0001));
    tick();
    check_eq("reject_drop", 64'(bus.reject_pulse), 64'd0);
    req(4'b1001, 16'd0, 16'd0, 16'd0, 16'h0003, 1'b0);
    check_eq("reject_ton0_wave3", 64'(bus.reject_pulse), 64'd1);
    req(4'b0100, 16'd0, 16'd0, 16'd78, 16'd0, 1'b0);
    check_eq("accept_ip78", 64'(bus.pending), 64'd4);
    check_eq("accept_no_reject", 64'(bus.reject_pulse), 64'd0);
    sb_q.push_back(pset(16'd30, 16'd80, 16'd78, 16'h0001));
    req(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    check_eq("boundary_ip", 64'(bus.Ip_data), 64'd78);

    // Last request wins; a request on the boundary cycle joins the commit
    req(4'b0001, 16'd40, 16'd0, 16'd0, 16'd0, 1'b0);
    sb_q.push_back(pset(16'd41, 16'd80, 16'd78, 16'h0001));
    req(4'b0001, 16'd41, 16'd0, 16'd0, 16'd0, 1'b1);
    check_eq("same_cycle_ton", 64'(bus.Ton_data), 64'd41);
    check_eq("same_cycle_commit", 64'(bus.commit_pulse), 64'd1);

    // Waveform change: drain until the power stage goes idle
    bus.is_operation = 1'b1;
    req(4'b1000, 16'd0, 16'd0, 16'd0, 16'h0002, 1'b0);
    check_eq("drain_machine", 64'(bus.is_machine), 64'd0);
    check_eq("drain_pending", 64'(bus.pending), 64'd8);
    repeat (100) tick();
    req(4'b0100, 16'd0, 16'd0, 16'd50, 16'd0, 1'b0);
    repeat (199) tick();
    check_eq("drain_wave_held", 64'(bus.waveform_data), 64'h0001);
    sb_q.push_back(pset(16'd41, 16'd80, 16'd50, 16'h0002));
    bus.is_operation = 1'b0;
    tick();
    check_eq("drain_wave", 64'(bus.waveform_data), 64'h0002);
    check_eq("drain_commit", 64'(bus.commit_pulse), 64'd1);
    check_eq("resume_machine", 64'(bus.is_machine), 64'd0);
    tick();
    check_eq("resumed_machine", 64'(bus.is_machine), 64'd1);
    check_eq("no_fault", 64'(bus.drain_fault), 64'd0);

    // Drain timeout with is_operation stuck high
    bus.is_operation = 1'b1;
    sb_q.push_back(pset(16'd41, 16'd80, 16'd50, 16'h8000));
    req(4'b1000, 16'd0, 16'd0, 16'd0, 16'h8000, 1'b0);
    n = 0;
    while (bus.commit_pulse !== 1'b1 && n < 20100) begin
      tick();
      n++;
    end
    check_eq("timeout_cycles", 64'(n), 64'd20000);
    check_eq("timeout_fault", 64'(bus.drain_fault), 64'd1);
    check_eq("timeout_wave", 64'(bus.waveform_data), 64'h8000);
    bus.is_operation = 1'b0;
    tick();
    tick();
    check_eq("timeout_resumed", 64'(bus.is_machine), 64'd1);
    check_eq("fault_sticky", 64'(bus.drain_fault), 64'd1);

    // Run-source priority: stop beats start, key stop blocks SPI start
    runctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("spi_stop_wins", 64'(bus.is_machine), 64'd0);
    runctl(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check_eq("key_stop_spi_start", 64'(bus.is_machine), 64'd0);
    runctl(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("key_restart", 64'(bus.is_machine), 64'd1);

    // Reset in the middle of a drain discards staged data
    bus.is_operation = 1'b1;
    req(4'b1000, 16'd0, 16'd0, 16'd0, 16'h0002, 1'b0);
    repeat (5) tick();
    check_eq("pre_rst_drain", 64'(bus.is_machine), 64'd0);
    rst = 1'b1;
    tick();
    check_defaults("mid_rst");
    rst = 1'b0;
    bus.is_operation = 1'b0;
    repeat (5) tick();
    check_eq("post_rst_params", params(), pset(16'd10, 16'd50, 16'd20, 16'h0001));
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
